// File: rtl/adc_sample_averager.sv
// adc_sample_averager: block averager for a stream of unsigned ADC samples.
// Sums 2^LOG2_N consecutive valid samples, emits the rounded mean over a
// valid/ready handshake and flags results overwritten before acceptance.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   en              averaging enable; low idles and drops any partial window
//   sample_in       ADC sample word, qualified by sample_valid
//   sample_valid    one-cycle strobe per sample
//   avg_out         rounded window mean
//   avg_valid       avg_out holds an unaccepted result
//   avg_ready       consumer accepts avg_out when avg_valid & avg_ready
//   overrun         sticky: a pending result was overwritten
//   ovr_clr         synchronous clear of overrun (wins over a same-cycle set)
//   win_min/win_max min/max of the last completed window
//
// Optional feature macro: ADC_AVG_MINMAX_EN enables win_min/win_max tracking;
// when undefined both outputs are tied to zero.
module adc_sample_averager #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LOG2_N = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] win_min,
    output logic [DATA_W-1:0] win_max
);

    localparam int unsigned ACC_W = DATA_W + LOG2_N;
    localparam int unsigned CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int unsigned N     = 32'd1 << LOG2_N;
    // Half an LSB of the shifted result; zero for a single-sample window.
    localparam int unsigned RND   = N >> 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic {S_IDLE, S_ACC} state_t;

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_avg_out;
    logic                r_avg_valid;
    logic                r_overrun;

    logic                w_take;
    logic                w_done;
    logic [ACC_W-1:0]    w_sum;
    logic [ACC_W-1:0]    w_rnd;
    logic [DATA_W-1:0]   w_avg;

    // Sample acceptance and window completion
    assign w_take = (r_state == S_ACC) && en && sample_valid;
    assign w_done = w_take && (r_count == LAST);

    // Max sum is N*(2^DATA_W-1); adding N/2 still fits in ACC_W bits
    assign w_sum = r_acc + ACC_W'(sample_in);
    assign w_rnd = w_sum + ACC_W'(RND);
    assign w_avg = DATA_W'(w_rnd >> LOG2_N);

    // Control FSM, accumulator and result/handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_avg_out   <= '0;
            r_avg_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_acc   <= '0;
                    r_count <= '0;
                    if (en) r_state <= S_ACC;
                end
                S_ACC: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_acc   <= '0;
                        r_count <= '0;
                    end else if (sample_valid) begin
                        if (w_done) begin
                            r_acc   <= '0;
                            r_count <= '0;
                        end else begin
                            r_acc   <= w_sum;
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A new result always loads; otherwise acceptance clears valid
            if (w_done) begin
                r_avg_out   <= w_avg;
                r_avg_valid <= 1'b1;
            end else if (r_avg_valid && avg_ready) begin
                r_avg_valid <= 1'b0;
            end

            if (ovr_clr)
                r_overrun <= 1'b0;
            else if (w_done && r_avg_valid && !avg_ready)
                r_overrun <= 1'b1;
        end
    end

    assign avg_out   = r_avg_out;
    assign avg_valid = r_avg_valid;
    assign overrun   = r_overrun;

`ifdef ADC_AVG_MINMAX_EN
    logic [DATA_W-1:0] r_run_min;
    logic [DATA_W-1:0] r_run_max;
    logic [DATA_W-1:0] r_win_min;
    logic [DATA_W-1:0] r_win_max;
    logic [DATA_W-1:0] w_min_nxt;
    logic [DATA_W-1:0] w_max_nxt;

    // First sample of a window seeds both running extremes
    assign w_min_nxt = ((r_count == '0) || (sample_in < r_run_min)) ? sample_in : r_run_min;
    assign w_max_nxt = ((r_count == '0) || (sample_in > r_run_max)) ? sample_in : r_run_max;

    // Running extremes; published together with the average
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_min <= '0;
            r_run_max <= '0;
            r_win_min <= '0;
            r_win_max <= '0;
        end else if (w_take) begin
            r_run_min <= w_min_nxt;
            r_run_max <= w_max_nxt;
            if (w_done) begin
                r_win_min <= w_min_nxt;
                r_win_max <= w_max_nxt;
            end
        end
    end

    assign win_min = r_win_min;
    assign win_max = r_win_max;
`else
    assign win_min = '0;
    assign win_max = '0;
`endif

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed testbench for adc_sample_averager: an 8-sample-window instance
// plus a single-sample (passthrough) instance sharing clock and reset.
module tb_adc_sample_averager;

    logic        clk;
    logic        rst_n;

    logic        en, sample_valid, avg_ready, ovr_clr;
    logic [15:0] sample_in;
    logic [15:0] avg_out, win_min, win_max;
    logic        avg_valid, overrun;

    logic        en_0, sample_valid_0, avg_ready_0, ovr_clr_0;
    logic [15:0] sample_in_0;
    logic [15:0] avg_out_0, win_min_0, win_max_0;
    logic        avg_valid_0, overrun_0;

    int n_checks;
    int n_fail;

    adc_sample_averager #(.DATA_W(16), .LOG2_N(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .avg_out(avg_out), .avg_valid(avg_valid), .avg_ready(avg_ready),
        .overrun(overrun), .ovr_clr(ovr_clr),
        .win_min(win_min), .win_max(win_max)
    );

    adc_sample_averager #(.DATA_W(16), .LOG2_N(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en_0),
        .sample_in(sample_in_0), .sample_valid(sample_valid_0),
        .avg_out(avg_out_0), .avg_valid(avg_valid_0), .avg_ready(avg_ready_0),
        .overrun(overrun_0), .ovr_clr(ovr_clr_0),
        .win_min(win_min_0), .win_max(win_max_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit past the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic feed_n(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) feed(v);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (avg_out !== 16'd0 || avg_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got avg=%0d valid=%b ovr=%b, expected 0 0 0", avg_out, avg_valid, overrun);
        end
        n_checks++;
        if (win_min !== 16'd0 || win_max !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_minmax: got min=%0d max=%0d, expected 0 0", win_min, win_max);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_average();
        avg_ready = 1'b1;
        en = 1'b1;
        step();
        feed(16'd100); feed(16'd200); feed(16'd300); feed(16'd400);
        feed(16'd500); feed(16'd600); feed(16'd700);
        n_checks++;
        if (avg_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_valid: got %b expected 0", avg_valid);
        end
        feed(16'd801);
        n_checks++;
        if (avg_valid !== 1'b1 || avg_out !== 16'd450) begin
            n_fail++;
            $display("FAIL basic_avg: got valid=%b avg=%0d, expected 1 450", avg_valid, avg_out);
        end
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_overrun: got %b expected 0", overrun);
        end
`ifdef ADC_AVG_MINMAX_EN
        n_checks++;
        if (win_min !== 16'd100 || win_max !== 16'd801) begin
            n_fail++;
            $display("FAIL basic_minmax: got min=%0d max=%0d, expected 100 801", win_min, win_max);
        end
`endif
        step();
        n_checks++;
        if (avg_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept: got valid=%b expected 0", avg_valid);
        end
    endtask

    task automatic test_full_scale();
        feed_n(16'hFFFF, 8);
        n_checks++;
        if (avg_valid !== 1'b1 || avg_out !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL full_scale: got valid=%b avg=%h, expected 1 ffff", avg_valid, avg_out);
        end
        step();
        feed(16'd5); feed(16'd9); feed(16'd1);
        feed_n(16'd7, 5);
        // sum 50 -> (50+4)>>3 = 6
        n_checks++;
        if (avg_out !== 16'd6) begin
            n_fail++;
            $display("FAIL minmax_window_avg: got %0d expected 6", avg_out);
        end
`ifdef ADC_AVG_MINMAX_EN
        n_checks++;
        if (win_min !== 16'd1 || win_max !== 16'd9) begin
            n_fail++;
            $display("FAIL minmax_window: got min=%0d max=%0d, expected 1 9", win_min, win_max);
        end
`else
        n_checks++;
        if (win_min !== 16'd0 || win_max !== 16'd0) begin
            n_fail++;
            $display("FAIL minmax_tied: got min=%0d max=%0d, expected 0 0", win_min, win_max);
        end
`endif
        step();
    endtask

    task automatic test_overrun();
        avg_ready = 1'b0;
        feed_n(16'd10, 8);
        n_checks++;
        if (avg_out !== 16'd10 || avg_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_first: got avg=%0d valid=%b ovr=%b, expected 10 1 0", avg_out, avg_valid, overrun);
        end
        feed_n(16'd20, 8);
        n_checks++;
        if (avg_out !== 16'd20 || avg_valid !== 1'b1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_second: got avg=%0d valid=%b ovr=%b, expected 20 1 1", avg_out, avg_valid, overrun);
        end
        step();
        n_checks++;
        if (overrun !== 1'b1 || avg_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky: got ovr=%b valid=%b, expected 1 1", overrun, avg_valid);
        end
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0 || avg_valid !== 1'b1 || avg_out !== 16'd20) begin
            n_fail++;
            $display("FAIL ovr_clear: got ovr=%b valid=%b avg=%0d, expected 0 1 20", overrun, avg_valid, avg_out);
        end
        avg_ready = 1'b1;
        step();
        avg_ready = 1'b0;
        n_checks++;
        if (avg_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_accept: got valid=%b expected 0", avg_valid);
        end
    endtask

    task automatic test_back_to_back();
        avg_ready = 1'b0;
        feed_n(16'd30, 8);
        feed_n(16'd50, 7);
        avg_ready = 1'b1;
        feed(16'd50);
        avg_ready = 1'b0;
        n_checks++;
        if (avg_out !== 16'd50 || avg_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept_load: got avg=%0d valid=%b ovr=%b, expected 50 1 0", avg_out, avg_valid, overrun);
        end
        feed_n(16'd60, 7);
        ovr_clr = 1'b1;
        feed(16'd60);
        ovr_clr = 1'b0;
        n_checks++;
        if (avg_out !== 16'd60 || avg_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_clr_priority: got avg=%0d valid=%b ovr=%b, expected 60 1 0", avg_out, avg_valid, overrun);
        end
        avg_ready = 1'b1;
        step();
        n_checks++;
        if (avg_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got valid=%b expected 0", avg_valid);
        end
    endtask

    task automatic test_abort();
        avg_ready = 1'b1;
        feed_n(16'd1000, 5);
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        feed_n(16'd40, 3);
        n_checks++;
        if (avg_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_partial: got valid=%b avg=%0d, expected valid 0", avg_valid, avg_out);
        end
`ifdef ADC_AVG_MINMAX_EN
        n_checks++;
        if (win_min !== 16'd60 || win_max !== 16'd60) begin
            n_fail++;
            $display("FAIL abort_minmax_hold: got min=%0d max=%0d, expected 60 60", win_min, win_max);
        end
`endif
        feed_n(16'd40, 5);
        n_checks++;
        if (avg_valid !== 1'b1 || avg_out !== 16'd40) begin
            n_fail++;
            $display("FAIL abort_result: got valid=%b avg=%0d, expected 1 40", avg_valid, avg_out);
        end
        step();
    endtask

    task automatic test_async_reset();
        avg_ready = 1'b0;
        feed_n(16'd70, 8);
        feed_n(16'd90, 3);
        n_checks++;
        if (avg_valid !== 1'b1 || avg_out !== 16'd70) begin
            n_fail++;
            $display("FAIL arst_setup: got valid=%b avg=%0d, expected 1 70", avg_valid, avg_out);
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (avg_out !== 16'd0 || avg_valid !== 1'b0 || overrun !== 1'b0 ||
            win_min !== 16'd0 || win_max !== 16'd0) begin
            n_fail++;
            $display("FAIL arst_outputs: got avg=%0d valid=%b ovr=%b min=%0d max=%0d, expected all 0",
                     avg_out, avg_valid, overrun, win_min, win_max);
        end
        #2 rst_n = 1'b1;
        step();
        feed_n(16'd80, 5);
        n_checks++;
        if (avg_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_count_cleared: got valid=%b expected 0", avg_valid);
        end
        feed_n(16'd80, 3);
        n_checks++;
        if (avg_valid !== 1'b1 || avg_out !== 16'd80) begin
            n_fail++;
            $display("FAIL arst_after: got valid=%b avg=%0d, expected 1 80", avg_valid, avg_out);
        end
        avg_ready = 1'b1;
        step();
    endtask

    task automatic test_passthrough();
        avg_ready_0 = 1'b1;
        en_0 = 1'b1;
        step();
        sample_in_0 = 16'd1234;
        sample_valid_0 = 1'b1;
        step();
        sample_valid_0 = 1'b0;
        n_checks++;
        if (avg_valid_0 !== 1'b1 || avg_out_0 !== 16'd1234) begin
            n_fail++;
            $display("FAIL pass_first: got valid=%b avg=%0d, expected 1 1234", avg_valid_0, avg_out_0);
        end
`ifdef ADC_AVG_MINMAX_EN
        n_checks++;
        if (win_min_0 !== 16'd1234 || win_max_0 !== 16'd1234) begin
            n_fail++;
            $display("FAIL pass_minmax: got min=%0d max=%0d, expected 1234 1234", win_min_0, win_max_0);
        end
`endif
        sample_in_0 = 16'd7;
        sample_valid_0 = 1'b1;
        step();
        sample_valid_0 = 1'b0;
        n_checks++;
        if (avg_valid_0 !== 1'b1 || avg_out_0 !== 16'd7 || overrun_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_second: got valid=%b avg=%0d ovr=%b, expected 1 7 0", avg_valid_0, avg_out_0, overrun_0);
        end
        step();
        n_checks++;
        if (avg_valid_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_accept: got valid=%b expected 0", avg_valid_0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b1;
        en = 1'b0; sample_valid = 1'b0; avg_ready = 1'b0; ovr_clr = 1'b0; sample_in = '0;
        en_0 = 1'b0; sample_valid_0 = 1'b0; avg_ready_0 = 1'b0; ovr_clr_0 = 1'b0; sample_in_0 = '0;
        test_reset();
        test_basic_average();
        test_full_scale();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_passthrough();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
- Downstream consumer of the ADS7683 serial ADC controller's 16-bit parallel sample word.
- Accumulates 2^LOG2_N consecutive valid samples and emits one rounded mean per window.
- Hands the mean to the next stage over a valid/ready handshake, with a sticky overrun flag.
- Provides a clean decimated sample stream for later processing and host readout.

Parameters:
- DATA_W, 16, sample and average width (unsigned straight binary).
- LOG2_N, 3, log2 of window length; legal range 0..8; window N = 2^LOG2_N samples.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  averaging enable; low = idle and discard partial window.
- sample_in  input  DATA_W  ADC sample word from the converter controller.
- sample_valid  input  1  one-cycle strobe; sample_in valid this cycle.
- avg_out  output  DATA_W  rounded window mean.
- avg_valid  output  1  avg_out holds an unaccepted result.
- avg_ready  input  1  consumer accepts avg_out when avg_valid & avg_ready.
- overrun  output  1  sticky; a result was overwritten before acceptance.
- ovr_clr  input  1  synchronous clear of overrun.
- win_min  output  DATA_W  minimum of the last completed window (feature-gated).
- win_max  output  DATA_W  maximum of the last completed window (feature-gated).

Behaviour:
- Reset (async, rst_n low) forces:
  - avg_out=0, avg_valid=0, overrun=0, win_min=0, win_max=0.
  - accumulator=0, count=0, state=IDLE.
- Accumulator width is DATA_W+LOG2_N; it never overflows.
- count width is max(LOG2_N,1).
- FSM states: IDLE, ACC.
  - IDLE: en=0; accumulator and count held at 0; sample_valid ignored; en=1 -> ACC next cycle.
  - ACC with sample_valid=1 and count<N-1: accumulator+=sample_in, count+=1.
  - ACC with sample_valid=1 and count==N-1 (window complete):
    - sum = accumulator + sample_in.
    - avg_out <= (sum + 2^(LOG2_N-1)) >> LOG2_N; the rounding term is 0 when LOG2_N=0.
    - Result never exceeds 2^DATA_W-1, so no saturation is needed.
    - avg_valid <= 1; accumulator <= 0; count <= 0.
  - ACC with en=0: go to IDLE; partial window discarded (accumulator=0, count=0) on that edge. Any sample_valid on that cycle is ignored.
- Latency: avg_valid rises on the clock edge that samples the Nth sample_valid, so it is visible the cycle after that strobe.
- LOG2_N=0: each valid sample passes through with 1-cycle latency.
- Handshake:
  - avg_valid stays high and avg_out stays stable until a cycle with avg_ready=1; avg_valid clears on that edge.
  - avg_ready while avg_valid=0 has no effect.
- Window completes while avg_valid=1:
  - avg_ready=1 same cycle: new result loaded, avg_valid stays 1, no overrun.
  - avg_ready=0: new result overwrites avg_out, avg_valid stays 1, overrun <= 1.
- overrun stays set until ovr_clr=1.
  - ovr_clr has priority over a simultaneous set: overrun = 0 after that edge.
- en deasserted with avg_valid=1: pending result is kept until accepted; handshake continues in IDLE.
- Reset mid-window or mid-handshake: immediate return to reset values; no result emitted.

Optional Feature:
- Macro ADC_AVG_MINMAX_EN.
- Defined:
  - Per-window running min/max registers track every accepted sample.
  - Both registers are seeded from the first sample of each window.
  - On window completion, win_min/win_max update on the same edge as avg_out; the completing sample is included.
  - win_min/win_max follow the same overwrite rules as avg_out and are not gated by the handshake.
  - A partial window discarded by en=0 leaves win_min/win_max unchanged.
- Undefined: win_min and win_max are tied to 0; no tracking logic is synthesized.

Test Plan:
- LOG2_N=3; feed 8 strobes with values 100,200,300,400,500,600,700,801 (sum 3601), avg_ready=1 -> avg_out=450 ((3601+4)>>3), avg_valid high exactly 1 cycle after the 8th strobe, overrun=0.
- LOG2_N=3; 8 samples of 16'hFFFF -> avg_out=16'hFFFF, no wrap. With the macro, 8 samples 5,9,1,7,7,7,7,7 -> win_min=1, win_max=9.
- avg_ready=0; complete two windows (first all 10, second all 20) -> avg_out=20, avg_valid=1, overrun=1. Pulse ovr_clr -> overrun=0. Raise avg_ready -> avg_valid drops next edge.
- Second window completes on the same cycle avg_ready=1 -> avg_out updates, avg_valid remains 1, overrun remains 0. Also ovr_clr and an overrun set in the same cycle -> overrun=0.
- Feed 5 samples of 1000, drop en for 1 cycle, re-enable, feed 8 samples of 40 -> single result avg_out=40, no result from the partial window.
- Assert rst_n=0 asynchronously mid-window with avg_valid=1 -> all outputs 0 before the next clk edge. LOG2_N=0 passthrough: sample 1234 -> avg_out=1234 one cycle later.
